// File: rtl/serial_pkg.sv
// Shared definitions for the UART receiver and transmitter: FSM state encoding
// and the bit-period calculation both ends must agree on.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Rounded clocks per bit, so a 48 MHz / 115200 link lands on 417 rather than 416.
    function automatic int unsigned clks_per_bit(input int unsigned clock_hz,
                                                 input int unsigned baud);
        return (clock_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Byte-stream handshake and status flags between the UART receiver and its consumer.
interface serial_receiver_if;

    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_busy;
    logic       framing_error;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_data_valid,
        input  rx_data_ready,
        output rx_busy,
        output framing_error,
        output overrun
    );

    modport slave (
        input  rx_data,
        input  rx_data_valid,
        output rx_data_ready,
        input  rx_busy,
        input  framing_error,
        input  overrun
    );

endinterface

// File: rtl/serial_sync.sv
// Two-flop synchronizer for an asynchronous level input; INIT sets the value
// both stages take in reset (1 for an idle-high UART line).
module serial_sync #(
    parameter logic INIT = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments make both stages update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= INIT;
            sync_q <= INIT;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/serial_receiver.sv
// UART 8N1 receiver, LSB first: mid-bit sampling, framing check, and a
// single-byte holding register behind a valid/ready handshake.
module serial_receiver
    import serial_pkg::*;
#(
    parameter int unsigned CLOCK_HZ = 48_000_000,
    parameter int unsigned BAUD     = 115_200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              serial_rx,
    serial_receiver_if.master rx_if
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_HZ, BAUD);
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             deliver_q, deliver_d;
    logic             framing_error_q, framing_error_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_data_valid_q, rx_data_valid_d;
    logic             overrun_q, overrun_d;

    serial_sync #(.INIT(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (serial_rx),
        .q     (rx_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            clk_cnt_q       <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            deliver_q       <= 1'b0;
            framing_error_q <= 1'b0;
            rx_data_q       <= '0;
            rx_data_valid_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            clk_cnt_q       <= clk_cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            deliver_q       <= deliver_d;
            framing_error_q <= framing_error_d;
            rx_data_q       <= rx_data_d;
            rx_data_valid_q <= rx_data_valid_d;
            overrun_q       <= overrun_d;
        end
    end

    // Frame sequencing; the counter is zeroed on every state change.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d         = state_q;
        clk_cnt_d       = clk_cnt_q + 1'b1;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        deliver_d       = 1'b0;
        framing_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        deliver_d       = 1'b1;
                        state_d         = IDLE;
                    end else begin
                        framing_error_d = 1'b1;
                        state_d         = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                clk_cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                clk_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    // Holding register: a byte drains on valid&&ready; a new byte arriving
    // while the old one is still held and not leaving is dropped as overrun.
    always_comb begin
        rx_data_d       = rx_data_q;
        rx_data_valid_d = rx_data_valid_q;
        overrun_d       = 1'b0;

        if (rx_data_valid_q && rx_if.rx_data_ready) rx_data_valid_d = 1'b0;

        if (deliver_q) begin
            if (!rx_data_valid_q || rx_if.rx_data_ready) begin
                rx_data_d       = shift_q;
                rx_data_valid_d = 1'b1;
            end else begin
                overrun_d       = 1'b1;
            end
        end
    end

    assign rx_if.rx_data       = rx_data_q;
    assign rx_if.rx_data_valid = rx_data_valid_q;
    assign rx_if.rx_busy       = (state_q != IDLE);
    assign rx_if.framing_error = framing_error_q;
    assign rx_if.overrun       = overrun_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: directed frames from the test plan
// plus random bytes with a random consumer, checked by a separate monitor.
module tb_serial_receiver;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int CPB  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 2;

    logic clk = 1'b0;
    logic rst;
    logic serial_rx;

    serial_receiver_if rx_if ();

    serial_receiver #(.CLOCK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clock     (clk),
        .reset     (rst),
        .serial_rx (serial_rx),
        .rx_if     (rx_if)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         fe_seen  = 0;
    int         ov_seen  = 0;
    int         fe_exp   = 0;
    int         ov_exp   = 0;
    logic       fe_prev  = 1'b0;
    logic       ov_prev  = 1'b0;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 ns before each rising edge, so valid&&ready seen here is a transfer.
    initial forever begin
        @(negedge clk);
        #4;
        if (rst) begin
            fe_prev = 1'b0;
            ov_prev = 1'b0;
        end else begin
            if (rx_if.rx_data_valid && rx_if.rx_data_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got byte %02h, expected none", rx_if.rx_data);
                end else begin
                    check("sb_byte", {24'h0, rx_if.rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (rx_if.framing_error) begin
                fe_seen++;
                check("fe_pulse_width", {31'h0, fe_prev}, 32'h0);
                check("fe_ov_exclusive", {31'h0, rx_if.overrun}, 32'h0);
            end
            if (rx_if.overrun) begin
                ov_seen++;
                check("ov_pulse_width", {31'h0, ov_prev}, 32'h0);
            end
            fe_prev = rx_if.framing_error;
            ov_prev = rx_if.overrun;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_ready) rx_if.rx_data_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        serial_rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_rx = bits[i];
            repeat (CPB) tick();
        end
    endtask

    initial begin
        int         k;
        int         n;
        logic [7:0] b;
        string      msg;

        rst = 1'b1;
        serial_rx = 1'b1;
        rx_if.rx_data_ready = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check("rst_rx_data", {24'h0, rx_if.rx_data}, 32'h0);
        check("rst_valid", {31'h0, rx_if.rx_data_valid}, 32'h0);
        check("rst_busy", {31'h0, rx_if.rx_busy}, 32'h0);
        check("rst_framing_error", {31'h0, rx_if.framing_error}, 32'h0);
        check("rst_overrun", {31'h0, rx_if.overrun}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(10);

        // Single byte with the consumer always ready, latency measured from the start edge.
        rx_if.rx_data_ready = 1'b1;
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            begin
                k = 0;
                while (!rx_if.rx_data_valid && k < LAT + 20) begin
                    @(negedge clk);
                    #4;
                    k++;
                end
                check("latency_window", {31'h0, (k >= LAT - 1 && k <= LAT + 1)}, 32'h1);
            end
        join
        idle(CPB);

        // Two back-to-back bytes with nobody reading: the second is an overrun.
        rx_if.rx_data_ready = 1'b0;
        exp_q.push_back(8'h48);
        send_frame(8'h48, 1'b1);
        send_frame(8'h0A, 1'b1);
        ov_exp++;
        idle(4);
        check("ovr_held_data", {24'h0, rx_if.rx_data}, 32'h48);
        check("ovr_held_valid", {31'h0, rx_if.rx_data_valid}, 32'h1);
        check("ovr_pulse_count", ov_seen, ov_exp);
        rx_if.rx_data_ready = 1'b1;
        #4;
        check("ovr_valid_before_accept", {31'h0, rx_if.rx_data_valid}, 32'h1);
        @(negedge clk);
        #4;
        check("ovr_valid_after_accept", {31'h0, rx_if.rx_data_valid}, 32'h0);
        idle(CPB);

        // Bad stop bit, line kept low: one framing error, parked until the line rises.
        send_frame(8'hA3, 1'b0);
        repeat (3 * CPB) tick();
        fe_exp++;
        check("fe_busy_while_low", {31'h0, rx_if.rx_busy}, 32'h1);
        check("fe_no_valid", {31'h0, rx_if.rx_data_valid}, 32'h0);
        check("fe_pulse_count", fe_seen, fe_exp);
        idle(4);
        check("fe_busy_after_high", {31'h0, rx_if.rx_busy}, 32'h0);
        exp_q.push_back(8'h31);
        send_frame(8'h31, 1'b1);
        idle(CPB);

        // Short low glitch on an idle line: busy only for the half-bit check.
        serial_rx = 1'b0;
        n = 0;
        for (int i = 0; i < 4 * CPB; i++) begin
            tick();
            if (i == HALF / 2 - 1) serial_rx = 1'b1;
            #4;
            if (rx_if.rx_busy) n++;
        end
        check("glitch_busy_window", {31'h0, (n >= HALF && n <= HALF + 2)}, 32'h1);
        check("glitch_fe_count", fe_seen, fe_exp);
        check("glitch_ov_count", ov_seen, ov_exp);
        tick();

        // Reset in the middle of bit 4 of a 0xFF frame.
        serial_rx = 1'b0;
        repeat (CPB) tick();
        serial_rx = 1'b1;
        repeat (4 * CPB + CPB / 2) tick();
        check("midframe_busy", {31'h0, rx_if.rx_busy}, 32'h1);
        rst = 1'b1;
        #1;
        check("midframe_rst_data", {24'h0, rx_if.rx_data}, 32'h0);
        check("midframe_rst_valid", {31'h0, rx_if.rx_data_valid}, 32'h0);
        check("midframe_rst_busy", {31'h0, rx_if.rx_busy}, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        idle(2 * CPB);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(CPB);

        // Continuous text stream, no idle time between frames.
        msg = "Hello world!\r\n";
        for (int i = 0; i < msg.len(); i++) begin
            exp_q.push_back(msg[i]);
            send_frame(msg[i], 1'b1);
        end
        idle(2 * CPB);

        // Random bytes, random gaps, random consumer stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            idle($urandom_range(0, 20));
        end
        rand_ready = 1'b0;
        rx_if.rx_data_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 10 * CPB) begin
            tick();
            k++;
        end
        idle(4);
        check("sb_drained", exp_q.size(), 32'h0);
        check("final_fe_count", fe_seen, fe_exp);
        check("final_ov_count", ov_seen, ov_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
